mem_bus_ctrl: RTL and testbench
===============================

MEM_BUS_CTRL -- requirements
Module: mem_bus_ctrl

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 15: maximum WAIT cycles before a timeout abort (timeout build only); range 1..255.
REQ-002 clk  input  1  clock; all state changes on the rising edge.
REQ-003 reset  input  1  reset, asynchronous, active-low.
REQ-004 mem_rd  input  1  read request from the control FSM (instruction fetch or data load).
REQ-005 mem_wr  input  1  write request from the control FSM (data store).
REQ-006 addr  input  32  byte address from the datapath address mux.
REQ-007 wdata  input  32  store data.
REQ-008 rdata  output  32  registered read data, held until the next completed read.
REQ-009 done  output  1  one-cycle pulse: transaction completed successfully.
REQ-010 busy  output  1  high while a transaction is in flight (WAIT or DONE); the datapath stalls on it.
REQ-011 err  output  1  sticky error flag.
REQ-012 err_clr  input  1  synchronous clear for err.
REQ-013 bus_req  output  1  external memory request, registered.
REQ-014 bus_we  output  1  external write strobe, valid with bus_req.
REQ-015 bus_addr  output  32  word-aligned external address, valid with bus_req.
REQ-016 bus_wdata  output  32  external write data, valid with bus_req.
REQ-017 bus_ack  input  1  external completion; for reads, bus_rdata is valid in the same cycle.
REQ-018 bus_rdata  input  32  external read data.

Function
REQ-019 States SHALL be IDLE, WAIT, DONE and ERR, with IDLE as the reset state.
REQ-020 IDLE: on (mem_rd|mem_wr) with addr[1:0]==0, latch addr, wdata and we (we=mem_wr), set bus_req=1 and enter WAIT, so bus_req rises one cycle after the request.
REQ-021 Simultaneous mem_rd and mem_wr SHALL be a write; mem_rd is ignored.
REQ-022 IDLE: a request with addr[1:0]!=0 SHALL enter ERR with no bus_req and set err.
REQ-023 WAIT: bus_req, bus_we, bus_addr and bus_wdata SHALL stay constant until bus_ack; mem_rd, mem_wr, addr and wdata changes are ignored.
REQ-024 WAIT with bus_ack: drop bus_req next cycle, capture bus_rdata into rdata on reads only (rdata unchanged on writes), then enter DONE.
REQ-025 DONE: done=1 for exactly one cycle, then IDLE; a request seen in DONE is ignored and must be held by the requester until IDLE.
REQ-026 Minimum latency SHALL be request to done = 3 cycles when bus_ack arrives in the first WAIT cycle.
REQ-027 bus_ack in IDLE, DONE or ERR SHALL be ignored.
REQ-028 ERR: bus_req=0, busy=0; go to IDLE on the next cycle.
REQ-029 err SHALL stay set until err_clr=1; if err_clr and a new error occur in the same cycle, err ends set.
REQ-030 busy = (state==WAIT)|(state==DONE).

Reset
REQ-031 Asserting reset SHALL force IDLE immediately, including mid-WAIT: bus_req, bus_we, done, busy and err = 0; bus_addr, bus_wdata and rdata = 0; timeout counter = 0.
REQ-032 On deassertion, the first request SHALL be accepted on the first rising edge with reset high.

Configuration
REQ-033 Macro MEM_BUS_TIMEOUT_EN defined: an 8-bit counter clears on WAIT entry and increments each WAIT cycle without bus_ack.
REQ-034 When the count reaches TIMEOUT_CYCLES without bus_ack, the block SHALL enter ERR, drop bus_req, and set err.
REQ-035 bus_ack arriving in the same cycle as the count limit SHALL win: normal completion, no err.
REQ-036 Macro MEM_BUS_TIMEOUT_EN undefined: no counter; WAIT holds indefinitely; err is set only by misalignment.

Verification
REQ-037 Read, addr=0x100, bus_ack in the first WAIT cycle with bus_rdata=0xDEADBEEF -> bus_req high 1 cycle, rdata=0xDEADBEEF, done pulse 3 cycles after the request.
REQ-038 Write, addr=0x200, wdata=0x12345678, bus_ack after 4 WAIT cycles -> bus_we=1 and bus_addr/bus_wdata held for 4 cycles, rdata unchanged, single done pulse.
REQ-039 mem_rd=mem_wr=1 at addr=0x40 -> bus_we=1; then a read at addr=0x42 -> no bus_req, err=1 sticky until err_clr.
REQ-040 Timeout build, TIMEOUT_CYCLES=15, no bus_ack -> bus_req drops after 15 WAIT cycles, err=1, no done; repeat with bus_ack on cycle 15 -> done, err=0.
REQ-041 Reset asserted on the second WAIT cycle -> bus_req=0 asynchronously, busy=0; a read after release completes normally.

Source files
------------

// File: rtl/mem_bus_ctrl.sv
// -----------------------------------------------------------------------------
// mem_bus_ctrl
//
// Bridges the CPU control FSM's memory requests onto a simple req/ack
// external bus. One transaction is in flight at a time:
//   IDLE -> WAIT (bus_req held) -> DONE (done pulse) -> IDLE
// Misaligned requests go IDLE -> ERR -> IDLE without touching the bus and set
// the sticky err flag.
//
// Optional feature (macro MEM_BUS_TIMEOUT_EN):
//   When defined, the parameter TIMEOUT_CYCLES (1..255, default 15) bounds the
//   number of WAIT cycles without bus_ack; on expiry the transaction is
//   abandoned through ERR and err is set. When undefined, WAIT holds forever
//   and err is set only by misalignment.
//
// Ports:
//   clk        in   clock, rising edge
//   reset      in   asynchronous reset, active-low
//   mem_rd     in   read request (fetch / load)
//   mem_wr     in   write request (store); wins over mem_rd
//   addr[31:0] in   byte address
//   wdata[31:0]in   store data
//   rdata[31:0]out  registered read data, held until the next completed read
//   done       out  one-cycle completion pulse
//   busy       out  high in WAIT and DONE (datapath stall)
//   err        out  sticky error flag
//   err_clr    in   synchronous clear for err
//   bus_req    out  registered external request
//   bus_we     out  external write strobe
//   bus_addr   out  word-aligned external address
//   bus_wdata  out  external write data
//   bus_ack    in   external completion (read data valid in same cycle)
//   bus_rdata  in   external read data
// -----------------------------------------------------------------------------
module mem_bus_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_rd,
  input  logic        mem_wr,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        done,
  output logic        busy,
  output logic        err,
  input  logic        err_clr,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

`ifdef MEM_BUS_TIMEOUT_EN
  parameter int unsigned TIMEOUT_CYCLES = 15;
  localparam logic [7:0] TMO_LIMIT = TIMEOUT_CYCLES[7:0];
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2,
    ERR  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic        bus_req_q, bus_req_d;
  logic        bus_we_q, bus_we_d;
  logic [31:0] bus_addr_q, bus_addr_d;
  logic [31:0] bus_wdata_q, bus_wdata_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
`ifdef MEM_BUS_TIMEOUT_EN
  logic [7:0]  tmo_q, tmo_d;
`endif

  always_comb begin
    state_d     = state_q;
    bus_req_d   = bus_req_q;
    bus_we_d    = bus_we_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    rdata_d     = rdata_q;
    // Clear first so that a new error in the same cycle overrides it.
    err_d       = err_clr ? 1'b0 : err_q;
`ifdef MEM_BUS_TIMEOUT_EN
    tmo_d       = tmo_q;
`endif

    case (state_q)
      IDLE: begin
        if (mem_rd || mem_wr) begin
          if (addr[1:0] == 2'b00) begin
            bus_req_d   = 1'b1;
            bus_we_d    = mem_wr;          // write wins when both are raised
            bus_addr_d  = {addr[31:2], 2'b00};
            bus_wdata_d = wdata;
            state_d     = WAIT;
`ifdef MEM_BUS_TIMEOUT_EN
            tmo_d       = 8'd0;
`endif
          end else begin
            err_d   = 1'b1;
            state_d = ERR;
          end
        end
      end

      WAIT: begin
        // Request inputs are ignored here; the latched bus fields stay put.
        if (bus_ack) begin
          bus_req_d = 1'b0;
          if (!bus_we_q) begin
            rdata_d = bus_rdata;
          end
          state_d = DONE;
        end else begin
`ifdef MEM_BUS_TIMEOUT_EN
          // Counter value equals the number of ack-less WAIT cycles seen;
          // an ack in the limit cycle takes the branch above instead.
          tmo_d = tmo_q + 8'd1;
          if (tmo_q + 8'd1 == TMO_LIMIT) begin
            bus_req_d = 1'b0;
            err_d     = 1'b1;
            state_d   = ERR;
          end
`endif
        end
      end

      DONE: state_d = IDLE;
      ERR:  state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      bus_req_q   <= 1'b0;
      bus_we_q    <= 1'b0;
      bus_addr_q  <= 32'd0;
      bus_wdata_q <= 32'd0;
      rdata_q     <= 32'd0;
      err_q       <= 1'b0;
`ifdef MEM_BUS_TIMEOUT_EN
      tmo_q       <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      bus_req_q   <= bus_req_d;
      bus_we_q    <= bus_we_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
`ifdef MEM_BUS_TIMEOUT_EN
      tmo_q       <= tmo_d;
`endif
    end
  end

  assign rdata     = rdata_q;
  assign done      = (state_q == DONE);
  assign busy      = (state_q == WAIT) || (state_q == DONE);
  assign err       = err_q;
  assign bus_req   = bus_req_q;
  assign bus_we    = bus_we_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_mem_bus_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_bus_ctrl
//
// Scoreboard bench for mem_bus_ctrl. The driver decides each transaction's
// outcome from the behavioural rules (aligned -> bus cycle, read data returns
// on ack, misaligned -> error, optional timeout) and pushes the expected bus
// request and completion data into queues. A monitor pops and compares them
// whenever the DUT raises bus_req or pulses done. A responder process plays the
// external memory, acking after a per-transaction number of WAIT cycles and
// throwing stray acks while no request is pending.
// -----------------------------------------------------------------------------
module tb_mem_bus_ctrl;

  localparam int TMO   = 15;
  localparam int NEVER = 100000;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_rd = 1'b0;
  logic        mem_wr = 1'b0;
  logic [31:0] addr = 32'd0;
  logic [31:0] wdata = 32'd0;
  logic [31:0] rdata;
  logic        done;
  logic        busy;
  logic        err;
  logic        err_clr = 1'b0;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = 32'd0;

  mem_bus_ctrl dut (
    .clk(clk), .reset(reset), .mem_rd(mem_rd), .mem_wr(mem_wr),
    .addr(addr), .wdata(wdata), .rdata(rdata), .done(done), .busy(busy),
    .err(err), .err_clr(err_clr), .bus_req(bus_req), .bus_we(bus_we),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_ack(bus_ack),
    .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event not allowed here", name);
  endtask

  // ---------------- reference model state / scoreboard ----------------
  typedef struct {
    logic        we;
    logic [31:0] a;
    logic [31:0] wd;
  } bus_t;

  bus_t        exp_bus_q[$];
  logic [31:0] exp_done_q[$];
  logic [31:0] model_rdata = 32'd0;
  logic        model_err   = 1'b0;

  // ---------------- external memory responder ----------------
  int          ack_after = NEVER;
  logic [31:0] ack_data  = 32'd0;
  bit          stray_en  = 1'b0;
  int          wcnt      = 0;

  always @(negedge clk) begin
    if (bus_req) wcnt = wcnt + 1;
    else         wcnt = 0;
    if (bus_req && wcnt == ack_after) begin
      bus_ack   = 1'b1;
      bus_rdata = ack_data;
    end else if (!bus_req && stray_en && $urandom_range(0, 3) == 0) begin
      bus_ack   = 1'b1;
      bus_rdata = $urandom;
    end else begin
      bus_ack   = 1'b0;
      bus_rdata = $urandom;
    end
  end

  // ---------------- monitor ----------------
  bit   prev_req = 1'b0;
  bus_t cur;

  always @(negedge clk) begin
    if (reset && bus_req && !prev_req) begin
      if (exp_bus_q.size() == 0) fail("unexpected_bus_req");
      else begin
        cur = exp_bus_q.pop_front();
        chk("bus_we", {31'd0, bus_we}, {31'd0, cur.we});
        chk("bus_addr", bus_addr, cur.a);
        chk("bus_wdata", bus_wdata, cur.wd);
      end
    end else if (reset && bus_req && prev_req) begin
      chk("bus_we_hold", {31'd0, bus_we}, {31'd0, cur.we});
      chk("bus_addr_hold", bus_addr, cur.a);
      chk("bus_wdata_hold", bus_wdata, cur.wd);
    end
    if (reset && done) begin
      if (exp_done_q.size() == 0) fail("unexpected_done");
      else chk("rdata_at_done", rdata, exp_done_q.pop_front());
    end
    prev_req = bus_req;
  end

  // ---------------- driver ----------------
  task automatic txn(input bit rd, input bit wr, input logic [31:0] a,
                     input logic [31:0] wd, input int ack_n, input logic [31:0] rdv);
    bit mis;
    bit tmo_hit;
    bit fin;
    int reqcnt;
    int bound;
    bus_t b;
    mis = (rd || wr) && (a[1:0] != 2'b00);
`ifdef MEM_BUS_TIMEOUT_EN
    tmo_hit = (ack_n > TMO);
`else
    tmo_hit = 1'b0;
`endif
    @(negedge clk);
    mem_rd = rd; mem_wr = wr; addr = a; wdata = wd;
    ack_after = ack_n; ack_data = rdv;
    if (mis) begin
      model_err = 1'b1;
      @(negedge clk);
      mem_rd = 1'b0; mem_wr = 1'b0;
      chk("mis_bus_req", {31'd0, bus_req}, 32'd0);
      chk("mis_busy", {31'd0, busy}, 32'd0);
      chk("mis_done", {31'd0, done}, 32'd0);
      chk("mis_err", {31'd0, err}, 32'd1);
      @(negedge clk);
      chk("mis_back_idle_busy", {31'd0, busy}, 32'd0);
      return;
    end
    b.we = wr; b.a = a; b.wd = wd;
    exp_bus_q.push_back(b);
    if (!tmo_hit) begin
      if (!wr) model_rdata = rdv;
      exp_done_q.push_back(model_rdata);
    end else begin
      model_err = 1'b1;
    end
    bound  = tmo_hit ? TMO + 3 : ack_n + 3;
    reqcnt = 0;
    fin    = 1'b0;
    for (int k = 1; k <= bound && !fin; k++) begin
      @(negedge clk);
      if (bus_req) reqcnt++;
      if (done) begin
        fin = 1'b1;
        if (tmo_hit) fail("done_after_timeout");
        else begin
          chk("done_latency", k, ack_n + 1);
          chk("bus_req_cycles", reqcnt, ack_n);
        end
      end else if (tmo_hit && !bus_req && !busy) begin
        fin = 1'b1;
        chk("timeout_latency", k, TMO + 1);
        chk("timeout_req_cycles", reqcnt, TMO);
        chk("timeout_err", {31'd0, err}, 32'd1);
      end
      if (fin) begin
        mem_rd = 1'b0; mem_wr = 1'b0;
      end else begin
        // Noise on the request inputs while in flight must be ignored.
        mem_rd = $urandom_range(0, 1); mem_wr = $urandom_range(0, 1);
        addr = $urandom; wdata = $urandom;
      end
    end
    mem_rd = 1'b0; mem_wr = 1'b0;
    if (!fin) fail("txn_no_completion");
    @(negedge clk);
    chk("done_single_pulse", {31'd0, done}, 32'd0);
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("err_state", {31'd0, err}, {31'd0, model_err});
  endtask

  task automatic clr_err();
    @(negedge clk);
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    model_err = 1'b0;
    chk("err_cleared", {31'd0, err}, 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    logic [31:0] a;
    int op;
    int an;

    #1;
    chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_err", {31'd0, err}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_bus_addr", bus_addr, 32'd0);
    @(posedge clk); #2 reset = 1'b1;

    // Directed cases
    txn(1'b1, 1'b0, 32'h100, 32'h0, 1, 32'hDEADBEEF);
    txn(1'b0, 1'b1, 32'h200, 32'h12345678, 4, 32'hA5A5A5A5);
    txn(1'b1, 1'b1, 32'h40, 32'hCAFEF00D, 2, 32'h11111111);
    txn(1'b1, 1'b0, 32'h42, 32'h0, 1, 32'h0);
    txn(1'b1, 1'b0, 32'h44, 32'h0, 3, 32'h0BADC0DE);
    clr_err();

    // err_clr together with a new error: error wins.
    @(negedge clk);
    mem_rd = 1'b1; addr = 32'h46; err_clr = 1'b1;
    @(negedge clk);
    mem_rd = 1'b0; err_clr = 1'b0; model_err = 1'b1;
    chk("clr_vs_new_err", {31'd0, err}, 32'd1);
    @(negedge clk);
    clr_err();

    // Long waits around the timeout limit
    txn(1'b1, 1'b0, 32'h500, 32'h0, TMO, 32'h55AA55AA);
    txn(1'b0, 1'b1, 32'h504, 32'h77777777, TMO + 1, 32'h0);
    txn(1'b1, 1'b0, 32'h508, 32'h0, 20, 32'h13572468);
`ifdef MEM_BUS_TIMEOUT_EN
    txn(1'b1, 1'b0, 32'h50C, 32'h0, NEVER, 32'h0);
`endif
    clr_err();

    // Randomized traffic with stray acks
    stray_en = 1'b1;
    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 5);
      a  = $urandom & 32'hFFFF_FFFC;
      an = ($urandom_range(0, 7) == 0) ? $urandom_range(TMO - 1, TMO + 3)
                                       : $urandom_range(1, 6);
      case (op)
        0, 1: txn(1'b1, 1'b0, a, $urandom, an, $urandom);
        2, 3: txn(1'b0, 1'b1, a, $urandom, an, $urandom);
        4:    txn(1'b1, 1'b1, a, $urandom, an, $urandom);
        default: begin
          a[1:0] = 2'($urandom_range(1, 3));
          txn($urandom_range(0, 1) == 1, 1'b1, a, $urandom, 1, $urandom);
        end
      endcase
      if ($urandom_range(0, 7) == 0) clr_err();
    end
    stray_en = 1'b0;

    // Reset during the second WAIT cycle
    @(negedge clk);
    mem_rd = 1'b1; addr = 32'h300; ack_after = NEVER;
    exp_bus_q.push_back('{we: 1'b0, a: 32'h300, wd: wdata});
    @(negedge clk);
    mem_rd = 1'b0;
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("midwait_rst_bus_req", {31'd0, bus_req}, 32'd0);
    chk("midwait_rst_busy", {31'd0, busy}, 32'd0);
    chk("midwait_rst_err", {31'd0, err}, 32'd0);
    chk("midwait_rst_rdata", rdata, 32'd0);
    chk("midwait_rst_bus_we", {31'd0, bus_we}, 32'd0);
    chk("midwait_rst_bus_addr", bus_addr, 32'd0);
    chk("midwait_rst_bus_wdata", bus_wdata, 32'd0);
    model_rdata = 32'd0;
    model_err   = 1'b0;
    @(posedge clk); #2 reset = 1'b1;
    txn(1'b1, 1'b0, 32'h304, 32'h0, 2, 32'hFEEDFACE);
    txn(1'b0, 1'b1, 32'h308, 32'h24681357, 1, 32'h0);

    repeat (3) @(negedge clk);
    chk("bus_queue_empty", exp_bus_q.size(), 32'd0);
    chk("done_queue_empty", exp_done_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_time_limit: simulation did not finish, expected finish");
    $fatal(1);
  end

endmodule
